// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Definitions shared by the instruction fetch unit and its next-PC calculator:
// the fetch FSM state encoding, the PC increment, and the MIPS instruction
// bitfield positions used for jump and branch targets.
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_TRAP  = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_STEP = 4;

    // MIPS instruction word fields
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int JIDX_MSB   = 25;
    localparam int JIDX_LSB   = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;

endpackage : fetch_pkg

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC selection for the fetch unit.
// Priority: register jump > absolute jump > relative branch > sequential.
//
// Ports:
//   pc_plus4   in   ADDR_W  address following the current instruction
//   instr      in   32      current instruction word (jump index / immediate)
//   dobranch   in   1       relative branch taken
//   dojump     in   1       absolute jump (j/jal)
//   dojumpreg  in   1       jump to register (jr)
//   rs_value   in   32      register operand, jr target
//   next_pc    out  ADDR_W  selected next program counter
// ---------------------------------------------------------------------------
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [31:0]       instr,
    input  logic              dobranch,
    input  logic              dojump,
    input  logic              dojumpreg,
    input  logic [31:0]       rs_value,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] br_offset;
    logic [ADDR_W-1:0] br_target;

    always_comb begin
        // Jump keeps the top nibble of the sequential address (region select).
        jump_target = {pc_plus4[ADDR_W-1:28], instr[JIDX_MSB:JIDX_LSB], 2'b00};
        // Word offset sign-extended to byte offset; the sum wraps naturally.
        br_offset   = {{(ADDR_W-IMM_W-2){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
        br_target   = pc_plus4 + br_offset;

        if (dojumpreg) begin
            next_pc = rs_value[ADDR_W-1:0];
        end else if (dojump) begin
            next_pc = jump_target;
        end else if (dobranch) begin
            next_pc = br_target;
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule : next_pc_calc

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Owns the program counter, fetches one instruction word at a time over a
// level request / valid response memory port, holds the word for the decoder
// until the datapath retires it, then steps to the next PC.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   Adds output fetch_trap and a TRAP state entered when a retired
//   instruction produces a next PC with bits [1:0] != 0. Left only by reset.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   imem_req/imem_addr    fetch request (level) and byte address (= pc)
//   imem_rdata/imem_valid returned instruction word and its strobe
//   instr/instr_valid     held instruction word to the decoder
//   advance               datapath retires instr this cycle
//   dobranch/dojump/dojumpreg, rs_value  next-PC controls from the decoder
//   pc, pc_plus4          address of held instruction and its link value
//   fetch_trap            (FETCH_MISALIGN_TRAP_EN only) misaligned target trap
//   retired_cnt           count of retired instructions (wraps)
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              advance,
    input  logic              dobranch,
    input  logic              dojump,
    input  logic              dojumpreg,
    input  logic [31:0]       rs_value,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic              fetch_trap,
`endif
    output logic [31:0]       retired_cnt
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       retired_cnt_q, retired_cnt_d;
    logic              imem_req_q, imem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic              fetch_trap_q, fetch_trap_d;
    logic [ADDR_W-1:0] next_pc;

    assign pc_plus4 = pc_q + ADDR_W'(PC_STEP);

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_calc (
        .pc_plus4  (pc_plus4),
        .instr     (instr_q),
        .dobranch  (dobranch),
        .dojump    (dojump),
        .dojumpreg (dojumpreg),
        .rs_value  (rs_value),
        .next_pc   (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        retired_cnt_d = retired_cnt_q;
        imem_req_d    = imem_req_q;
        instr_valid_d = instr_valid_q;
        fetch_trap_d  = fetch_trap_q;

        case (state_q)
            ST_REQ: begin
                // A response only counts once the request is actually visible
                // on the port; the first REQ cycle after reset has it low.
                if (imem_req_q && imem_valid) begin
                    instr_d       = imem_rdata;
                    state_d       = ST_ISSUE;
                    imem_req_d    = 1'b0;
                    instr_valid_d = 1'b1;
                end else begin
                    imem_req_d    = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (advance) begin
                    pc_d          = next_pc;
                    retired_cnt_d = retired_cnt_q + 32'd1;
                    instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (next_pc[1:0] != 2'b00) begin
                        state_d      = ST_TRAP;
                        fetch_trap_d = 1'b1;
                        imem_req_d   = 1'b0;
                    end else begin
                        state_d      = ST_REQ;
                        imem_req_d   = 1'b1;
                    end
`else
                    state_d       = ST_REQ;
                    imem_req_d    = 1'b1;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_TRAP: begin
                fetch_trap_d = 1'b1;
                imem_req_d   = 1'b0;
            end
`endif
            default: begin
                state_d       = ST_REQ;
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            retired_cnt_q <= 32'h0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_trap_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            retired_cnt_q <= retired_cnt_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            fetch_trap_q  <= fetch_trap_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign retired_cnt = retired_cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_trap  = fetch_trap_q;
`else
    logic unused_trap;
    assign unused_trap = fetch_trap_q;
`endif

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Transaction-level bench for instr_fetch_unit: each instruction is a fetch
// with a chosen memory latency, a stall of chosen length and a retirement
// with chosen decoder controls. The expected PC sequence comes from the
// architectural next-PC rules applied to a model PC.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic        instr_valid;
    logic        advance;
    logic        dobranch;
    logic        dojump;
    logic        dojumpreg;
    logic [31:0] rs_value;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired_cnt;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_trap;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .advance     (advance),
        .dobranch    (dobranch),
        .dojump      (dojump),
        .dojumpreg   (dojumpreg),
        .rs_value    (rs_value),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_trap  (fetch_trap),
`endif
        .retired_cnt (retired_cnt)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural next-PC rule, written with plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] w,
                                             input logic br, input logic j, input logic jr,
                                             input logic [31:0] rs);
        logic [31:0] seq;
        logic [31:0] off;
        seq = cur_pc + 32'd4;
        off = 32'($signed(w[15:0])) * 32'd4;
        if (jr)      return rs;
        else if (j)  return {seq[31:28], w[25:0], 2'b00};
        else if (br) return seq + off;
        else         return seq;
    endfunction

    task automatic random_ctrl();
        dobranch  = 1'($urandom_range(0, 1));
        dojump    = 1'($urandom_range(0, 1));
        dojumpreg = 1'($urandom_range(0, 1));
        rs_value  = $urandom;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        advance    = 1'b0;
        imem_valid = 1'b0;
        random_ctrl();
        @(negedge clk);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_ivalid", 32'(instr_valid), 32'd0);
        check_eq("rst_pc", pc, RST_PC);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_cnt", retired_cnt, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("rst_trap", 32'(fetch_trap), 32'd0);
`endif
        reset = 1'b0;
        m_pc  = RST_PC;
        m_cnt = 32'h0;
    endtask

    // Wait for the request, answer it in the lat-th request cycle with w.
    task automatic fetch(input int lat, input logic [31:0] w, output int waited);
        waited = 0;
        while (!imem_req && waited < 4) begin
            imem_valid = 1'b0;
            advance    = 1'($urandom_range(0, 1));
            random_ctrl();
            @(negedge clk);
            waited++;
        end
        if (!imem_req) begin
            check_eq("req_timeout", 32'(imem_req), 32'd1);
            return;
        end
        for (int c = 1; c <= lat; c++) begin
            check_eq("req_hi", 32'(imem_req), 32'd1);
            check_eq("req_addr", imem_addr, m_pc);
            check_eq("req_ivalid", 32'(instr_valid), 32'd0);
            imem_valid = (c == lat);
            imem_rdata = (c == lat) ? w : $urandom;
            advance    = 1'($urandom_range(0, 1));
            random_ctrl();
            @(negedge clk);
        end
        imem_valid = 1'b0;
        advance    = 1'b0;
        m_instr    = w;
        check_eq("iss_req", 32'(imem_req), 32'd0);
        check_eq("iss_ivalid", 32'(instr_valid), 32'd1);
        check_eq("iss_instr", instr, m_instr);
        check_eq("iss_pc", pc, m_pc);
        check_eq("iss_pc4", pc_plus4, m_pc + 32'd4);
    endtask

    // Hold for stall cycles, then retire with the given controls.
    task automatic retire(input int stall, input logic br, input logic j, input logic jr,
                          input logic [31:0] rs);
        logic [31:0] nxt;
        for (int s = 0; s < stall; s++) begin
            advance    = 1'b0;
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            random_ctrl();
            @(negedge clk);
            check_eq("stall_instr", instr, m_instr);
            check_eq("stall_pc", pc, m_pc);
            check_eq("stall_ivalid", 32'(instr_valid), 32'd1);
            check_eq("stall_req", 32'(imem_req), 32'd0);
        end
        imem_valid = 1'b0;
        advance    = 1'b1;
        dobranch   = br;
        dojump     = j;
        dojumpreg  = jr;
        rs_value   = rs;
        nxt        = ref_next(m_pc, m_instr, br, j, jr, rs);
        @(negedge clk);
        advance    = 1'b0;
        dobranch   = 1'b0;
        dojump     = 1'b0;
        dojumpreg  = 1'b0;
        m_pc       = nxt;
        m_cnt      = m_cnt + 32'd1;
        check_eq("ret_cnt", retired_cnt, m_cnt);
        check_eq("ret_ivalid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waited;
        int          lat;
        int          stall;
        logic [31:0] rs;
        logic        br, j, jr;

        reset      = 1'b1;
        advance    = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        dobranch   = 1'b0;
        dojump     = 1'b0;
        dojumpreg  = 1'b0;
        rs_value   = 32'h0;
        @(negedge clk);
        do_reset();

        // Zero-wait memory, retire immediately: addresses 0, 4, 8.
        for (int k = 0; k < 3; k++) begin
            fetch(1, 32'h2408_0005, waited);
            if (k > 0) check_eq("b2b_gap", 32'(waited), 32'd0);
            retire(0, 1'b0, 1'b0, (k == 2), 32'h0000_0010);
        end
        check_eq("cnt_after3", retired_cnt, 32'd3);

        // Branch with offset -1 word from pc 0x10 lands back on 0x10.
        fetch(1, 32'h1000_FFFF, waited);
        retire(0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("br_back", m_pc, 32'h0000_0010);
        fetch(1, 32'h0000_0000, waited);
        retire(1, 1'b0, 1'b0, 1'b1, 32'h1000_0020);

        // Absolute jump in the 0x1xxx_xxxx region.
        fetch(2, 32'h0800_0040, waited);
        check_eq("jal_link", pc_plus4, 32'h1000_0024);
        retire(0, 1'b0, 1'b1, 1'b0, 32'h0);
        fetch(1, 32'hDEAD_0001, waited);
        check_eq("jmp_pc", pc, 32'h1000_0100);

        // All controls at once: register jump wins.
        retire(0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        fetch(1, 32'h0000_0000, waited);
        check_eq("prio_pc", pc, 32'h0000_0200);

        // Sequential wrap at the top of the address space.
        retire(0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        fetch(1, 32'h0000_0000, waited);
        check_eq("wrap_pc4", pc_plus4, 32'h0000_0000);
        retire(0, 1'b0, 1'b0, 1'b0, 32'h0);
        fetch(1, 32'h0000_0000, waited);
        check_eq("wrap_pc", pc, 32'h0000_0000);

        // Slow memory and long stall, then reset during the next fetch.
        retire(0, 1'b0, 1'b0, 1'b0, 32'h0);
        fetch(5, 32'h8C22_0004, waited);
        retire(3, 1'b0, 1'b0, 1'b0, 32'h0);
        imem_valid = 1'b0;
        check_eq("wait_req1", 32'(imem_req), 32'd1);
        @(negedge clk);
        check_eq("wait_req2", 32'(imem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_pc", pc, RST_PC);
        check_eq("midrst_ivalid", 32'(instr_valid), 32'd0);
        check_eq("midrst_req", 32'(imem_req), 32'd0);
        check_eq("midrst_cnt", retired_cnt, 32'h0);
        reset = 1'b0;
        m_pc  = RST_PC;
        m_cnt = 32'h0;

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            lat   = $urandom_range(1, 4);
            stall = $urandom_range(0, 3);
            fetch(lat, $urandom, waited);
            if (it > 0) check_eq("rnd_gap", 32'(waited), 32'd0);
            br = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 3) == 0);
            jr = ($urandom_range(0, 3) == 0);
            rs = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            rs[1:0] = 2'b00;
`endif
            retire(stall, br, j, jr, rs);
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned register jump traps and holds until reset.
        do_reset();
        fetch(1, 32'h0000_0008, waited);
        retire(0, 1'b0, 1'b0, 1'b1, 32'h0000_0102);
        for (int t = 0; t < 5; t++) begin
            check_eq("trap_flag", 32'(fetch_trap), 32'd1);
            check_eq("trap_req", 32'(imem_req), 32'd0);
            check_eq("trap_ivalid", 32'(instr_valid), 32'd0);
            check_eq("trap_pc", pc, 32'h0000_0102);
            advance    = 1'($urandom_range(0, 1));
            imem_valid = 1'($urandom_range(0, 1));
            random_ctrl();
            @(negedge clk);
        end
        advance    = 1'b0;
        imem_valid = 1'b0;
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_instr_fetch_unit
